// File: rtl/stream_arbiter_pkg.sv
// Shared constants for the stream arbiter / crossbar slice: parameter
// defaults and the per-sink arbiter state encoding.
package stream_arbiter_pkg;

  localparam int S_DATA_COUNT_DEF = 5;
  localparam int M_DATA_COUNT_DEF = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// One sink's round-robin packet arbiter: picks a source while idle and holds
// the grant until that source's last beat is accepted.
module rr_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int S_DATA_COUNT = S_DATA_COUNT_DEF,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_DATA_COUNT-1:0] req,
  input  logic [S_DATA_COUNT-1:0] s_valid,
  input  logic [S_DATA_COUNT-1:0] s_last,
  input  logic                    m_ready,
  output logic [S_DATA_COUNT-1:0] pick,
  output logic [S_DATA_COUNT-1:0] grant,
  output logic                    m_valid,
  output logic                    m_last,
  output logic [T_ID___WIDTH-1:0] m_id
);

  arb_state_e              state;
  logic [T_ID___WIDTH-1:0] rr_ptr;
  logic [T_ID___WIDTH-1:0] sel;
  logic                    found;
  logic                    done;

  // First requester at or after rr_ptr, scanning circularly.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    pick  = '0;
    for (int k = 0; k < S_DATA_COUNT; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= S_DATA_COUNT) idx = idx - S_DATA_COUNT;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = T_ID___WIDTH'(idx);
      end
    end
    if (state == ARB_IDLE && found) pick[sel] = 1'b1;
  end

  assign done    = (state == ARB_BUSY) && m_ready && |(grant & s_valid & s_last);
  assign m_valid = |(grant & s_valid);
  assign m_last  = |(grant & s_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      m_id   <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (found) begin
          grant <= pick;
          m_id  <= sel;
          state <= ARB_BUSY;
        end
        ARB_BUSY: if (done) begin
          grant  <= '0;
          rr_ptr <= (int'(m_id) == S_DATA_COUNT - 1) ? '0 : m_id + 1'b1;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Packet-level crossbar arbiter: S sources routed to M sinks by s_dest_i,
// one round-robin arbiter per sink, grant matrix drives the data path.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int S_DATA_COUNT = S_DATA_COUNT_DEF,
  parameter int M_DATA_COUNT = M_DATA_COUNT_DEF,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
  output logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o
);

  logic [S_DATA_COUNT-1:0] busy_src;

  always_comb begin
    busy_src  = '0;
    s_ready_o = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      busy_src  = busy_src | grant_o[i*S_DATA_COUNT +: S_DATA_COUNT];
      s_ready_o = s_ready_o |
                  (grant_o[i*S_DATA_COUNT +: S_DATA_COUNT] & {S_DATA_COUNT{m_ready_i[i]}});
    end
  end

  for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_sink
    logic [S_DATA_COUNT-1:0] req;
    logic [S_DATA_COUNT-1:0] claimed;
    logic [S_DATA_COUNT-1:0] pick;

    always_comb begin
      req = '0;
      for (int j = 0; j < S_DATA_COUNT; j++)
        req[j] = s_valid_i[j] && (s_dest_i[j*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(i));
    end

    // Sources picked this cycle by lower-index sinks are off limits here.
    if (i == 0) begin : g_first
      assign claimed = '0;
    end else begin : g_next
      assign claimed = g_sink[i-1].claimed | g_sink[i-1].pick;
    end

    rr_arbiter #(
      .S_DATA_COUNT(S_DATA_COUNT),
      .T_ID___WIDTH(T_ID___WIDTH)
    ) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req & ~busy_src & ~claimed),
      .s_valid(s_valid_i),
      .s_last (s_last_i),
      .m_ready(m_ready_i[i]),
      .pick   (pick),
      .grant  (grant_o[i*S_DATA_COUNT +: S_DATA_COUNT]),
      .m_valid(m_valid_o[i]),
      .m_last (m_last_o[i]),
      .m_id   (m_id_o[i*T_ID___WIDTH +: T_ID___WIDTH])
    );
  end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 SHALL have parameter S_DATA_COUNT, default 5, number of source ports.
REQ-002 SHALL have parameter M_DATA_COUNT, default 3, number of sink ports.
REQ-003 SHALL have parameter T_ID___WIDTH, default $clog2(S_DATA_COUNT), source index width.
REQ-004 SHALL have parameter T_DEST_WIDTH, default $clog2(M_DATA_COUNT), destination field width.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port s_valid_i  input  S_DATA_COUNT  per-source beat valid.
REQ-008 SHALL have port s_last_i  input  S_DATA_COUNT  per-source last beat of packet.
REQ-009 SHALL have port s_dest_i  input  T_DEST_WIDTH*S_DATA_COUNT  per-source target sink, source j at slice j.
REQ-010 SHALL have port s_ready_o  output  S_DATA_COUNT  per-source ready.
REQ-011 SHALL have port m_ready_i  input  M_DATA_COUNT  per-sink ready.
REQ-012 SHALL have port m_valid_o  output  M_DATA_COUNT  per-sink valid.
REQ-013 SHALL have port m_last_o  output  M_DATA_COUNT  per-sink last.
REQ-014 SHALL have port m_id_o  output  T_ID___WIDTH*M_DATA_COUNT  granted source index per sink.
REQ-015 SHALL have port grant_o  output  S_DATA_COUNT*M_DATA_COUNT  one-hot-or-zero grant, bit i*S_DATA_COUNT+j = sink i owned by source j; drives the crossbar data path.

Function
REQ-016 Request req[i][j] SHALL be s_valid_i[j] AND s_dest_i[j]==i; s_dest_i values >= M_DATA_COUNT SHALL never be granted and SHALL see s_ready_o low.
REQ-017 Each sink SHALL run an independent FSM with states IDLE and BUSY.
REQ-018 IDLE: if any req[i][*], SHALL select the first requesting source at or after rr_ptr[i] (circular), register it into grant_o, m_id_o and enter BUSY on the next edge; otherwise remain IDLE.
REQ-019 Grant latency SHALL be exactly 1 cycle from first req to grant_o/m_valid_o assertion.
REQ-020 BUSY: m_valid_o[i]=s_valid_i[g], m_last_o[i]=s_last_i[g], s_ready_o[g]=m_ready_i[i], combinationally, g = granted source.
REQ-021 BUSY SHALL hold grant regardless of s_valid_i gaps or s_dest_i changes until a beat with valid, ready and last all high.
REQ-022 On that last-beat handshake: rr_ptr[i] SHALL become (g+1) mod S_DATA_COUNT, grant cleared, FSM to IDLE; one idle cycle between packets on a sink is required.
REQ-023 In IDLE, m_valid_o[i], m_last_o[i] SHALL be 0 and grant row i all zero; m_id_o[i] holds last value.
REQ-024 A source SHALL be granted by at most one sink at a time; a source held BUSY elsewhere SHALL be excluded from other sinks' arbitration.
REQ-025 Sources not granted SHALL see s_ready_o low.
REQ-026 Simultaneous IDLE arbitration on several sinks SHALL proceed in parallel, lower sink index winning any conflict per REQ-024.

Reset
REQ-027 rst_n low SHALL asynchronously force all FSMs IDLE, grant_o=0, m_valid_o=0, m_last_o=0, s_ready_o=0, m_id_o=0, rr_ptr=0.
REQ-028 Reset mid-packet SHALL abandon the packet; first arbitration after release restarts from source 0.

Structure
REQ-029 Shared constants (parameter defaults, state encodings IDLE=0/BUSY=1) SHALL live in one shared package/header used by crossbar and stream_arbiter.
REQ-030 Per-sink logic SHALL be one sub-module rr_arbiter, instantiated M_DATA_COUNT times.

Verification
REQ-031 Sources 1,3 request sink 0 same cycle after reset -> source 1 granted next cycle, grant_o bit 1 set; after its last handshake source 3 granted.
REQ-032 Source 2 sends 4-beat packet to sink 2, m_ready_i[2] toggled 1,0,1 -> grant held all beats, s_ready_o[2] mirrors m_ready_i[2], released after beat 4 last.
REQ-033 Sources 0 and 4 target sinks 0 and 1 -> both granted in same cycle, grant_o bits 0 and 9 high.
REQ-034 Source 0 s_dest_i=3 -> no grant, s_ready_o[0]=0, indefinitely.
REQ-035 rst_n low during beat 2 of a packet -> all outputs 0 immediately, rr_ptr restarts at 0.
REQ-036 All 5 sources continuously target sink 1 -> grant order 0,1,2,3,4,0, each packet separated by one idle cycle.
